// File: rtl/ps2_cmd_pkg.sv
// Shared constants and types for the PS/2 command line parser.
// ASCII codes, FSM state encodings, token sub-states, limits.
package ps2_cmd_pkg;

  localparam int LINE_CHARS = 32;
  localparam int LINE_BITS  = LINE_CHARS * 8;
  localparam logic [4:0] LAST_IDX = 5'(LINE_CHARS - 1);

  localparam logic [3:0]  MAX_DIGITS = 4'd9;
  localparam logic [31:0] ANGLE_MAX  = 32'd359;

  localparam logic [7:0] CH_NUL   = 8'h00;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2c;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  // Letters are lower case; compare against (char | 8'h20).
  localparam logic [7:0] CH_V     = 8'h76;
  localparam logic [7:0] CH_A     = 8'h61;
  localparam logic [7:0] CH_F     = 8'h66;
  localparam logic [7:0] CH_Q     = 8'h71;
  localparam logic [7:0] CH_R     = 8'h72;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  typedef enum logic [1:0] {
    TOK_NONE,
    TOK_VEL,
    TOK_ANG
  } tok_e;

endpackage

// File: rtl/ps2_decimal_accumulator.sv
// Decimal accumulator: acc = acc*10 + d with a digit counter.
// Ports: clock, resetn, clear, enable, digit -> value_next, count_next, too_many_digits.
module ps2_decimal_accumulator
  import ps2_cmd_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        clear,
  input  logic        enable,
  input  logic [3:0]  digit,
  output logic [31:0] value_next,
  output logic [3:0]  count_next,
  output logic        too_many_digits
);

  logic [31:0] acc;
  logic [3:0]  cnt;

  // Next values are exported so a token ending on the last
  // character can be finalized with that character included.
  always_comb begin
    value_next = acc;
    count_next = cnt;
    if (clear) begin
      value_next = '0;
      count_next = '0;
    end else if (enable) begin
      value_next = (acc << 3) + (acc << 1) + {28'd0, digit};
      count_next = cnt + 4'd1;
    end
  end

  assign too_many_digits = enable && !clear && (cnt >= MAX_DIGITS);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      acc <= value_next;
      cnt <= count_next;
    end
  end

endmodule

// File: rtl/ps2_command_parser.sv
// Validates a 32-char ASCII command line and commits velocity/angle/strobes.
// Ports: clock, resetn, line_in, line_valid -> velocity, angle, fire, queue, game_reset, done, parse_error, busy.
module ps2_command_parser
  import ps2_cmd_pkg::*;
(
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [LINE_BITS-1:0] line_in,
  input  logic                 line_valid,
  output logic [31:0]          velocity,
  output logic [31:0]          angle,
  output logic                 fire,
  output logic                 queue,
  output logic                 game_reset,
  output logic                 done,
  output logic                 parse_error,
  output logic                 busy
);

  logic [1:0]           state;
  logic [LINE_BITS-1:0] shadow;
  logic [4:0]           idx;
  tok_e                 tok;
  logic                 err;
  logic [31:0]          stg_vel;
  logic [31:0]          stg_ang;
  logic                 has_vel;
  logic                 has_ang;
  logic                 pend_f;
  logic                 pend_q;
  logic                 pend_r;

  logic [7:0]  c;
  logic [7:0]  lc;
  logic        is_nul, is_sep, is_dig;
  logic        is_v, is_a, is_f, is_q, is_r;
  logic        last, fin, bad;
  logic        acc_clr, acc_en, too_many;
  logic [31:0] val_eff;
  logic [3:0]  cnt_eff;
  tok_e        tok_eff;

  // The shadow shifts left each cycle, so the current char is always on top.
  assign c    = shadow[LINE_BITS-1 -: 8];
  assign lc   = c | 8'h20;
  assign busy = (state != ST_IDLE);
  assign last = (idx == LAST_IDX);

  always_comb begin
    is_nul  = (c == CH_NUL);
    is_sep  = (c == CH_SPACE) || (c == CH_COMMA);
    is_dig  = (c >= CH_0) && (c <= CH_9);
    is_v    = !is_nul && (lc == CH_V);
    is_a    = !is_nul && (lc == CH_A);
    is_f    = !is_nul && (lc == CH_F);
    is_q    = !is_nul && (lc == CH_Q);
    is_r    = !is_nul && (lc == CH_R);
    fin     = is_nul || is_sep || last;
    acc_en  = (state == ST_SCAN) && (tok != TOK_NONE) && is_dig;
    acc_clr = (state == ST_SCAN) && (tok == TOK_NONE) && (is_v || is_a);
    tok_eff = tok;
    if (tok == TOK_NONE && is_v) tok_eff = TOK_VEL;
    if (tok == TOK_NONE && is_a) tok_eff = TOK_ANG;
  end

  ps2_decimal_accumulator u_acc (
    .clock           (clock),
    .resetn          (resetn),
    .clear           (acc_clr),
    .enable          (acc_en),
    .digit           (c[3:0]),
    .value_next      (val_eff),
    .count_next      (cnt_eff),
    .too_many_digits (too_many)
  );

  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      is_nul, is_sep: bad = 1'b0;
      is_v, is_a, is_f, is_q, is_r: bad = (tok != TOK_NONE);
      is_dig: bad = (tok == TOK_NONE) || too_many;
      default: bad = 1'b1;
    endcase
    if (fin && !bad) begin
      if (tok_eff != TOK_NONE && cnt_eff == 4'd0) bad = 1'b1;
      if (tok_eff == TOK_ANG && val_eff > ANGLE_MAX) bad = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      shadow      <= '0;
      idx         <= '0;
      tok         <= TOK_NONE;
      err         <= 1'b0;
      stg_vel     <= '0;
      stg_ang     <= '0;
      has_vel     <= 1'b0;
      has_ang     <= 1'b0;
      pend_f      <= 1'b0;
      pend_q      <= 1'b0;
      pend_r      <= 1'b0;
      velocity    <= '0;
      angle       <= '0;
      fire        <= 1'b0;
      queue       <= 1'b0;
      game_reset  <= 1'b0;
      done        <= 1'b0;
      parse_error <= 1'b0;
    end else begin
      fire        <= 1'b0;
      queue       <= 1'b0;
      game_reset  <= 1'b0;
      done        <= 1'b0;
      parse_error <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (line_valid) begin
            shadow  <= line_in;
            idx     <= '0;
            tok     <= TOK_NONE;
            err     <= 1'b0;
            has_vel <= 1'b0;
            has_ang <= 1'b0;
            pend_f  <= 1'b0;
            pend_q  <= 1'b0;
            pend_r  <= 1'b0;
            state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          shadow <= shadow << 8;
          idx    <= idx + 5'd1;
          if (bad) begin
            err   <= 1'b1;
            state <= ST_COMMIT;
          end else begin
            tok <= fin ? TOK_NONE : tok_eff;
            if (is_f) pend_f <= 1'b1;
            if (is_q) pend_q <= 1'b1;
            if (is_r) pend_r <= 1'b1;
            if (fin && tok_eff == TOK_VEL) begin
              stg_vel <= val_eff;
              has_vel <= 1'b1;
            end
            if (fin && tok_eff == TOK_ANG) begin
              stg_ang <= val_eff;
              has_ang <= 1'b1;
            end
            if (is_nul || last) state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          if (err) begin
            parse_error <= 1'b1;
          end else begin
            if (has_vel) velocity <= stg_vel;
            if (has_ang) angle <= stg_ang;
            fire       <= pend_f;
            queue      <= pend_q;
            game_reset <= pend_r;
            done       <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_command_parser.sv
// Scoreboard bench for ps2_command_parser.
// Drives command lines, queues expected commits, checks on strobes.
module tb_ps2_command_parser;

  logic         clock = 1'b0;
  logic         resetn;
  logic [255:0] line_in;
  logic         line_valid;
  logic [31:0]  velocity;
  logic [31:0]  angle;
  logic         fire;
  logic         queue;
  logic         game_reset;
  logic         done;
  logic         parse_error;
  logic         busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          lat;
    logic [31:0] vel;
    logic [31:0] ang;
    int          nf;
    int          nq;
    int          nr;
    int          nd;
    int          ne;
  } exp_t;

  exp_t sb[$];

  ps2_command_parser dut (
    .clock       (clock),
    .resetn      (resetn),
    .line_in     (line_in),
    .line_valid  (line_valid),
    .velocity    (velocity),
    .angle       (angle),
    .fire        (fire),
    .queue       (queue),
    .game_reset  (game_reset),
    .done        (done),
    .parse_error (parse_error),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic logic [255:0] to_line(input string s);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < s.len() && i < 32; i++)
      v[255-8*i -: 8] = s[i];
    return v;
  endfunction

  task automatic run_line(input string s,
                          input int lat,
                          input logic [31:0] vel,
                          input logic [31:0] ang,
                          input int nf, input int nq,
                          input int nr, input int nd,
                          input int ne,
                          input string intr);
    exp_t e;
    exp_t x;
    int k;
    int cf, cq, cr, cd, ce;
    int trail;
    logic seen;
    logic [31:0] ov, oa;
    e.lat = lat; e.vel = vel; e.ang = ang;
    e.nf = nf; e.nq = nq; e.nr = nr;
    e.nd = nd; e.ne = ne;
    @(negedge clock);
    line_in    = to_line(s);
    line_valid = 1'b1;
    sb.push_back(e);
    @(posedge clock);
    #1 line_valid = 1'b0;
    cf = 0; cq = 0; cr = 0; cd = 0; ce = 0;
    seen = 1'b0; k = 0; ov = '0; oa = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (i == 1) chk({s, " busy_run"}, 32'(busy), 1);
      if (i == 2 && intr != "") begin
        line_in    = to_line(intr);
        line_valid = 1'b1;
      end
      if (i == 3) line_valid = 1'b0;
      cf += int'(fire); cq += int'(queue);
      cr += int'(game_reset);
      cd += int'(done); ce += int'(parse_error);
      if (done || parse_error) begin
        seen = 1'b1;
        k  = i;
        ov = velocity;
        oa = angle;
        chk({s, " busy_end"}, 32'(busy), 0);
        break;
      end
    end
    if (!seen) begin
      chk({s, " timeout"}, 0, 1);
      void'(sb.pop_front());
      return;
    end
    trail = (intr != "") ? 30 : 2;
    for (int i = 0; i < trail; i++) begin
      @(posedge clock);
      #1;
      cf += int'(fire); cq += int'(queue);
      cr += int'(game_reset);
      cd += int'(done); ce += int'(parse_error);
    end
    x = sb.pop_front();
    chk({s, " lat"}, 32'(k), 32'(x.lat));
    chk({s, " vel"}, ov, x.vel);
    chk({s, " ang"}, oa, x.ang);
    chk({s, " fire"}, 32'(cf), 32'(x.nf));
    chk({s, " queue"}, 32'(cq), 32'(x.nq));
    chk({s, " rst"}, 32'(cr), 32'(x.nr));
    chk({s, " done"}, 32'(cd), 32'(x.nd));
    chk({s, " err"}, 32'(ce), 32'(x.ne));
  endtask

  initial begin
    string s7, sfr, sv;
    int cd, cs;
    resetn     = 1'b0;
    line_in    = '0;
    line_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst vel", velocity, 0);
    chk("rst ang", angle, 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst perr", 32'(parse_error), 0);
    @(negedge clock) resetn = 1'b1;

    run_line("V120 A45 F", 12, 120, 45, 1, 0, 0, 1, 0, "");
    run_line("A360", 6, 120, 45, 0, 0, 0, 0, 1, "");
    run_line("V1234567890", 12, 120, 45, 0, 0, 0, 0, 1, "");
    run_line("Q R q", 7, 120, 45, 0, 1, 1, 1, 0, "");
    run_line("", 2, 120, 45, 0, 0, 0, 1, 0, "");
    s7 = "";
    for (int i = 0; i < 32; i++) s7 = {s7, "7"};
    run_line(s7, 2, 120, 45, 0, 0, 0, 0, 1, "");
    run_line("v7,a359", 9, 7, 359, 0, 0, 0, 1, 0, "");
    run_line("V999999999", 12, 999999999, 359, 0, 0, 0, 1, 0, "");
    run_line("A", 3, 999999999, 359, 0, 0, 0, 0, 1, "");
    run_line("V5 V6", 7, 6, 359, 0, 0, 0, 1, 0, "");
    run_line("Fv", 4, 6, 359, 0, 0, 0, 0, 1, "");
    sfr = "F";
    for (int i = 0; i < 30; i++) sfr = {sfr, " "};
    sfr = {sfr, "R"};
    run_line(sfr, 33, 6, 359, 1, 0, 1, 1, 0, "");
    sv = "";
    for (int i = 0; i < 22; i++) sv = {sv, " "};
    sv = {sv, "V123456789"};
    run_line(sv, 33, 123456789, 359, 0, 0, 0, 1, 0, "");
    run_line("A0", 4, 123456789, 0, 0, 0, 0, 1, 0, "");
    run_line("V77 A77", 9, 77, 77, 0, 0, 0, 1, 0, "V88");

    @(negedge clock);
    line_in    = to_line("V55 A55");
    line_valid = 1'b1;
    @(posedge clock);
    #1 line_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("mid busy", 32'(busy), 1);
    @(negedge clock) resetn = 1'b0;
    #1;
    chk("mid vel", velocity, 0);
    chk("mid ang", angle, 0);
    chk("mid busy0", 32'(busy), 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    cd = 0; cs = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      cd += int'(done) + int'(parse_error);
      cs += int'(fire) + int'(queue) + int'(game_reset);
    end
    chk("post done", 32'(cd), 0);
    chk("post strobes", 32'(cs), 0);
    chk("post vel", velocity, 0);

    run_line("V3", 4, 3, 0, 0, 0, 0, 1, 0, "");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_command_parser.md
# ps2_command_parser

- Consumes one completed 32-character ASCII command line from the PS/2 line-assembly stage, presented as a 256-bit vector plus a one-cycle ready pulse.
- Scans the line one character per clock and validates the whole line.
- Commits launch parameters (velocity, angle) and one-cycle command strobes (fire, queue, game reset) to the game logic only if the entire line parses cleanly; a malformed line changes nothing and raises an error pulse.

## Interface
- LINE_CHARS, 32, characters per line; char 0 in bits [255:248], char i in bits [255-8i -: 8].
- MAX_DIGITS, 9, maximum decimal digits per numeric argument.
- ANGLE_MAX, 359, largest legal angle value.

- clock  in  1  single system clock, rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- line_in  in  256  ASCII line, zero-padded after the last character.
- line_valid  in  1  one-cycle pulse: line_in is complete.
- velocity  out  32  last committed velocity, unsigned.
- angle  out  32  last committed angle, unsigned, 0..ANGLE_MAX.
- fire  out  1  one-cycle strobe.
- queue  out  1  one-cycle strobe.
- game_reset  out  1  one-cycle strobe.
- done  out  1  one-cycle strobe: line committed successfully.
- parse_error  out  1  one-cycle strobe: line rejected.
- busy  out  1  high whenever state is not IDLE.

## Operation
- **States**
  - IDLE: on line_valid, capture line_in into a shadow register, clear staging, set idx=0, go to SCAN. line_valid is ignored in any other state; there is no queueing.
  - SCAN: process char[idx] once per cycle.
  - COMMIT: apply staging or flag the error, then return to IDLE.
- **Token sub-state:** NONE, VEL or ANG.
- **Character rules in SCAN**
  - 0x00: finalize the current token, then go to COMMIT.
  - Space or ',': finalize the current token; token sub-state becomes NONE.
  - 'V'/'v' or 'A'/'a' in NONE: enter VEL or ANG and clear the accumulator.
  - Digits '0'-'9' in VEL/ANG: acc = acc*10 + d (computed as (acc<<3)+(acc<<1)+d). Digit count is limited to MAX_DIGITS.
  - 'F', 'Q', 'R' (either case) in NONE: set the matching pending flag. Repeats are idempotent.
  - Anything else, or a letter while in VEL/ANG: error.
  - Processing idx = LINE_CHARS-1 without meeting 0x00 counts as an implicit terminator.
- **Token finalize**
  - VEL/ANG with zero digits: error.
  - ANG value > ANGLE_MAX: error.
  - Otherwise stage the value. If the token repeats, the last one wins.
- **Error:** set a sticky error flag and skip straight to COMMIT; the remaining characters are not scanned.
- **COMMIT, error clear**
  - Write the staged velocity and/or angle; only fields that are present change.
  - Pulse each pending strobe and pulse done.
- **COMMIT, error set:** pulse parse_error only. No output register changes.
- An empty line (char 0 = 0x00) commits nothing and pulses done.

## Timing
- **Reset values:** velocity=0, angle=0, all strobes 0, busy=0, state IDLE. This applies at any time; a line in flight is discarded and no strobe is emitted.
- **Capture:** line_valid sampled at edge E0.
- **Scan:** char idx is processed at edge E(idx+1).
- **Completion:** a terminator at index n reaches COMMIT at E(n+1). Outputs and strobes are registered and valid for exactly the one cycle after edge E(n+2), when busy falls.
- **Error timing:** an error at char k commits at E(k+2).
- **Worst case:** a full line with no terminator commits at E33.
- **busy:** high from after E0 through the COMMIT cycle.
- **Back-to-back lines:** the next line_valid is accepted on the edge after COMMIT. line_valid coincident with COMMIT is dropped.
- **Accumulator width:** 32 bits. With MAX_DIGITS=9 the value is ≤ 999,999,999, so no overflow is possible. The 10th digit raises an error rather than wrapping.

## Structure
- **Package ps2_cmd_pkg:** ASCII constants (NUL, SPACE, COMMA, '0', '9', command letters), the state and token-state enums, and LINE_CHARS.
- **Sub-module ps2_decimal_accumulator:** owns the accumulator, the ×10+d update, digit count, clear/enable inputs and a too_many_digits flag.
- **Top level:** FSM, shadow line register, character mux, staging registers and output registers.

## Test plan
- "V120 A45 F" (terminator at idx 10):
  - velocity=120 and angle=45 after E12.
  - fire and done high for one cycle; queue and game_reset stay 0.
- "A360":
  - parse_error pulses.
  - velocity and angle keep their prior values (e.g. 120/45); no strobes.
- "V1234567890" (10 digits): error at the 10th digit; parse_error at E12; no updates.
- "Q R q": queue and game_reset each pulse exactly once.
- Second line_valid during busy, then resetn asserted mid-SCAN:
  - the second line is ignored;
  - after reset all outputs are 0 and no done/strobe appears.
- Empty line, then 32 × '7' with no terminator:
  - first: done only;
  - second: parse_error at E2, since '7' is illegal in NONE.
